// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding, owner ids and address check for the data RAM arbiter
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // Misaligned or beyond the last word; compares all 32 address bits so
  // large addresses never alias back onto low words.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned size);
    logic [31:0] word;
    word = addr >> 2;
    return (addr[1:0] != 2'b00) || (word >= size);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one master's request/ack channel into the data RAM arbiter
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_owner
);

  // Lone requester wins; under contention the one not granted last time wins.
  always_comb begin
    gnt_valid = |req;
    gnt_owner = OWNER_M0;
    if (req == 2'b11) begin
      gnt_owner = ~last_grant;
    end else if (req[1]) begin
      gnt_owner = OWNER_M1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master sequencer for the single-port data RAM
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int SIZE        = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int INIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_arbiter_if.slave         m0,
  dmem_arbiter_if.slave         m1,
  output logic [31:0]           ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_write,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  state_t                state;
  logic [31:0]           init_cnt;
  logic                  owner_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic                  last_grant;
  logic                  m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic                  gnt_valid, gnt_owner;
  logic                  ram_cycle;

  rr_arb2 u_arb (
    .req        ({m1.req, m0.req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  // Sequencer: INIT -> IDLE -> CHECK -> ACCESS -> RESP. A rejected request
  // still spends its ACCESS cycle (with the RAM untouched) so latency is fixed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      owner_q    <= OWNER_M0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      last_grant <= OWNER_M1;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_cnt + 32'd1 >= 32'(INIT_CYCLES)) begin
            state <= ST_IDLE;
          end else begin
            init_cnt <= init_cnt + 32'd1;
          end
        end
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_owner;
            if (gnt_owner == OWNER_M1) begin
              we_q    <= m1.we;
              addr_q  <= m1.addr;
              wdata_q <= m1.wdata;
            end else begin
              we_q    <= m0.we;
              addr_q  <= m0.addr;
              wdata_q <= m0.wdata;
            end
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_q <= addr_bad(addr_q, SIZE);
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (owner_q == OWNER_M1) begin
            m1_ack_q <= 1'b1;
            m1_err_q <= err_q;
            if (!err_q && !we_q) m1_rdata_q <= ram_data_out;
          end else begin
            m0_ack_q <= 1'b1;
            m0_err_q <= err_q;
            if (!err_q && !we_q) m0_rdata_q <= ram_data_out;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          last_grant <= owner_q;
          state      <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // RAM strobes come straight from the state register so a reset removes
  // them at once, dropping any write that was in flight.
  assign ram_cycle      = (state == ST_ACCESS) && !err_q;
  assign ram_address    = ram_cycle ? addr_q : '0;
  assign ram_data_write = (ram_cycle && we_q) ? wdata_q : '0;
  assign ram_write_en   = ram_cycle && we_q;
  assign ram_read_en    = ram_cycle && !we_q;
  assign busy           = (state != ST_IDLE);

  assign m0.ack   = m0_ack_q;
  assign m0.err   = m0_err_q;
  assign m0.rdata = m0_rdata_q;
  assign m1.ack   = m1_ack_q;
  assign m1.err   = m1_err_q;
  assign m1.rdata = m1_rdata_q;

endmodule
